// File: rtl/aliens_march_ctrl.sv
// March command generator for the alien formation: frame-paced LEFT/RIGHT/DOWN
// pulses whose period shrinks as aliens are killed.
`timescale 1ns/1ps
module aliens_march_ctrl #(
   parameter int         BASE_PERIOD  = 30,
   parameter int         MIN_PERIOD   = 4,
   parameter int         SPEEDUP_STEP = 1,
   parameter logic [1:0] LEFT         = 2'd1,
   parameter logic [1:0] RIGHT        = 2'd2,
   parameter logic [1:0] DOWN         = 2'd3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frameTick,
   input  logic       canLeft,
   input  logic       canRight,
   input  logic       defeat,
   input  logic       victory,
   input  logic       killingAlien,
   output logic [1:0] motion,
   output logic       stepPulse,
   output logic [7:0] killCount,
   output logic       halted
);

   typedef enum logic [1:0] {IDLE, MARCH_R, MARCH_L, HALT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  frame_cnt, frame_cnt_nxt, period;
   logic [1:0]  motion_nxt;
   logic        kill_prev, kill_edge, step_due;
   logic [15:0] slow_down, period_raw, period_calc;

   assign kill_edge = killingAlien & ~kill_prev & (state != HALT);

   // Subtraction saturates at zero before the floor is applied.
   always_comb begin
      slow_down   = 16'(killCount) * 16'(SPEEDUP_STEP);
      period_raw  = (slow_down >= 16'(BASE_PERIOD)) ? 16'd0 : 16'(BASE_PERIOD) - slow_down;
      period_calc = (period_raw < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period_raw;
   end

   // >= rather than == so a period that shrank below the counter still fires next tick.
   assign step_due = (9'(frame_cnt) + 9'd1) >= 9'(period);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = frame_cnt;
      motion_nxt    = 2'd0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt     = MARCH_R;
               frame_cnt_nxt = 8'd0;
            end
         end
         MARCH_R, MARCH_L: begin
            if (defeat || victory) begin
               state_nxt = HALT;
            end else if (frameTick) begin
               if (step_due) begin
                  frame_cnt_nxt = 8'd0;
                  if (state == MARCH_R) begin
                     if (canRight) motion_nxt = RIGHT;
                     else begin
                        motion_nxt = DOWN;
                        state_nxt  = MARCH_L;
                     end
                  end else begin
                     if (canLeft) motion_nxt = LEFT;
                     else begin
                        motion_nxt = DOWN;
                        state_nxt  = MARCH_R;
                     end
                  end
               end else begin
                  frame_cnt_nxt = frame_cnt + 8'd1;
               end
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_cnt <= 8'd0;
         motion    <= 2'd0;
         stepPulse <= 1'b0;
         halted    <= 1'b0;
         kill_prev <= 1'b0;
         killCount <= 8'd0;
         period    <= 8'(BASE_PERIOD);
      end else begin
         frame_cnt <= frame_cnt_nxt;
         motion    <= motion_nxt;
         stepPulse <= (motion_nxt != 2'd0);
         halted    <= (state_nxt == HALT);
         kill_prev <= killingAlien;
         if (kill_edge && killCount != 8'hFF) killCount <= killCount + 8'd1;
         period    <= period_calc[7:0];
      end
   end

endmodule

// File: tb/tb_aliens_march_ctrl.sv
// Directed bench for aliens_march_ctrl: step pacing, direction changes,
// kill speedup, halt priority and asynchronous reset.
`timescale 1ns/1ps
module tb_aliens_march_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, frameTick, canLeft, canRight, defeat, victory, killingAlien;
   logic [1:0] motion;
   logic       stepPulse;
   logic [7:0] killCount;
   logic       halted;

   int errors = 0;
   int checks = 0;

   int         steps;
   logic [1:0] last_m, last_after;
   logic       last_sp;

   aliens_march_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .frameTick(frameTick),
      .canLeft(canLeft), .canRight(canRight), .defeat(defeat), .victory(victory),
      .killingAlien(killingAlien), .motion(motion), .stepPulse(stepPulse),
      .killCount(killCount), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // n frames, 4 clk apart; steps counts every cycle with non-zero motion
   task automatic frames(input int n, output int st, output logic [1:0] m,
                         output logic sp, output logic [1:0] after);
      st = 0; m = 2'd0; sp = 1'b0; after = 2'd0;
      for (int i = 0; i < n; i++) begin
         frameTick = 1'b1;
         @(posedge clk); #1 frameTick = 1'b0;
         m = motion; sp = stepPulse;
         if (motion != 2'd0) st++;
         @(posedge clk); #1 after = motion;
         if (motion != 2'd0) st++;
         for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (motion != 2'd0) st++;
         end
      end
   endtask

   task automatic kills(input int n, input int hi);
      for (int i = 0; i < n; i++) begin
         killingAlien = 1'b1;
         repeat (hi) @(posedge clk);
         #1 killingAlien = 1'b0;
         repeat (2) @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; frameTick = 1'b0; canLeft = 1'b1; canRight = 1'b1;
      defeat = 1'b0; victory = 1'b0; killingAlien = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_motion", 16'(motion), 16'd0);
      chk("rst_step", 16'(stepPulse), 16'd0);
      chk("rst_kills", 16'(killCount), 16'd0);
      chk("rst_halted", 16'(halted), 16'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // frameTick ignored in IDLE
      frames(35, steps, last_m, last_sp, last_after);
      chk("idle_no_steps", 16'(steps), 16'd0);

      pulse_start();
      frames(29, steps, last_m, last_sp, last_after);
      chk("first_29_quiet", 16'(steps), 16'd0);
      frames(1, steps, last_m, last_sp, last_after);
      chk("first_right", 16'(last_m), 16'd2);
      chk("first_steppulse", 16'(last_sp), 16'd1);
      chk("first_width", 16'(last_after), 16'd0);
      chk("first_one_step", 16'(steps), 16'd1);

      frames(29, steps, last_m, last_sp, last_after);
      chk("r2_quiet", 16'(steps), 16'd0);
      canRight = 1'b0;
      frames(1, steps, last_m, last_sp, last_after);
      chk("edge_down", 16'(last_m), 16'd3);
      chk("edge_down_once", 16'(steps), 16'd1);
      frames(29, steps, last_m, last_sp, last_after);
      chk("l_quiet", 16'(steps), 16'd0);
      frames(1, steps, last_m, last_sp, last_after);
      chk("then_left", 16'(last_m), 16'd1);

      // three kills -> period 27
      kills(3, 5);
      chk("kills_3", 16'(killCount), 16'd3);
      frames(26, steps, last_m, last_sp, last_after);
      chk("p27_quiet", 16'(steps), 16'd0);
      frames(1, steps, last_m, last_sp, last_after);
      chk("p27_step", 16'(last_m), 16'd1);

      // 26 kills -> period 4
      kills(23, 2);
      chk("kills_26", 16'(killCount), 16'd26);
      frames(3, steps, last_m, last_sp, last_after);
      chk("p4_quiet", 16'(steps), 16'd0);
      frames(1, steps, last_m, last_sp, last_after);
      chk("p4_step", 16'(last_m), 16'd1);

      // beyond BASE_PERIOD kills: subtraction saturates, floor holds, count saturates
      kills(240, 1);
      chk("kills_sat", 16'(killCount), 16'd255);
      frames(3, steps, last_m, last_sp, last_after);
      chk("floor_quiet", 16'(steps), 16'd0);
      frames(1, steps, last_m, last_sp, last_after);
      chk("floor_step", 16'(last_m), 16'd1);

      // both blocked: DOWN each step, direction toggles L->R->L->R
      canLeft = 1'b0; canRight = 1'b0;
      for (int i = 0; i < 3; i++) begin
         frames(3, steps, last_m, last_sp, last_after);
         chk("wide_quiet", 16'(steps), 16'd0);
         frames(1, steps, last_m, last_sp, last_after);
         chk("wide_down", 16'(last_m), 16'd3);
         chk("wide_once", 16'(steps), 16'd1);
      end
      canLeft = 1'b1; canRight = 1'b1;
      frames(4, steps, last_m, last_sp, last_after);
      chk("wide_end_right", 16'(last_m), 16'd2);

      // async reset while RIGHT is on the bus
      frames(3, steps, last_m, last_sp, last_after);
      frameTick = 1'b1;
      @(posedge clk); #1 frameTick = 1'b0;
      chk("pre_rst_right", 16'(motion), 16'd2);
      #2 reset = 1'b0;
      #1;
      chk("async_motion", 16'(motion), 16'd0);
      chk("async_step", 16'(stepPulse), 16'd0);
      chk("async_kills", 16'(killCount), 16'd0);
      @(posedge clk); #1 reset = 1'b1;
      frames(40, steps, last_m, last_sp, last_after);
      chk("post_rst_idle", 16'(steps), 16'd0);
      pulse_start();
      frames(30, steps, last_m, last_sp, last_after);
      chk("restart_one_step", 16'(steps), 16'd1);
      chk("restart_right", 16'(last_m), 16'd2);

      // defeat on a step-deciding tick wins
      frames(29, steps, last_m, last_sp, last_after);
      frameTick = 1'b1; defeat = 1'b1;
      @(posedge clk); #1 frameTick = 1'b0; defeat = 1'b0;
      chk("halt_motion", 16'(motion), 16'd0);
      chk("halt_flag", 16'(halted), 16'd1);
      kills(2, 2);
      pulse_start();
      frames(35, steps, last_m, last_sp, last_after);
      chk("halt_no_steps", 16'(steps), 16'd0);
      chk("halt_no_kills", 16'(killCount), 16'd0);
      chk("halt_sticky", 16'(halted), 16'd1);

      // victory also halts, from MARCH_L this time
      reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      chk("rst_clears_halt", 16'(halted), 16'd0);
      pulse_start();
      canRight = 1'b0;
      frames(30, steps, last_m, last_sp, last_after);
      chk("v_down", 16'(last_m), 16'd3);
      victory = 1'b1;
      @(posedge clk); #1 victory = 1'b0;
      chk("victory_halt", 16'(halted), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
